// File: rtl/prefetch_issue_sched.sv
// prefetch_issue_sched
//   Shares the L1D MSHR prefetch port between NUM_REQ prefetch engines.
//   Round-robin arbitration, block alignment, a DEPTH-entry FIFO and an
//   optional duplicate filter. Prefetches issue only while the MSHR file
//   reports a free entry.
//
//   Build option: define PF_FILTER_EN to build the duplicate filter
//   (FIFO + recently-issued compare, drop counter). Undefined: every grant
//   enqueues and drop_cnt_o is tied to zero.
//
// Ports
//   clock, reset   clock; synchronous active-high reset
//   req_valid_i    candidate valid per requester
//   req_addr_i     candidate byte address, requester i at [i*ADDR_W +: ADDR_W]
//   req_write_i    1 = prefetch for write
//   req_ready_o    candidate accepted this cycle (one-hot or zero)
//   mshr_avail_i   MSHR file can take a request
//   flush_i        discard buffered and filter state
//   pf_valid_o     prefetch request valid
//   pf_ready_i     cache accepts prefetch
//   pf_addr_o      block-aligned prefetch address
//   pf_cmd_o       M_PFR (5'b00010) or M_PFW (5'b00011)
//   drop_cnt_o     saturating count of filtered duplicates
module prefetch_issue_sched #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 40,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned FILT_N  = 4,
    parameter int unsigned LG_BLK  = 6
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ-1:0]        req_write_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic                      mshr_avail_i,
    input  logic                      flush_i,
    output logic                      pf_valid_o,
    input  logic                      pf_ready_i,
    output logic [ADDR_W-1:0]         pf_addr_o,
    output logic [4:0]                pf_cmd_o,
    output logic [15:0]               drop_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [4:0]  M_PFR = 5'b00010;
    localparam logic [4:0]  M_PFW = 5'b00011;
    localparam logic [ADDR_W-1:0] BLK_MASK = ~((ADDR_W'(1) << LG_BLK) - ADDR_W'(1));

    logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
    logic [DEPTH-1:0]  fifo_wr_q;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [RR_W-1:0]   rr_q, rr_d;

    logic              gnt_found;
    logic [RR_W-1:0]   gnt_idx;
    logic [ADDR_W-1:0] gnt_addr;
    logic [ADDR_W-1:0] gnt_addr_al;
    logic              gnt_write;
    logic              full, empty, grant, hit, enq, fire;

    // First valid requester at or after rr, searched modulo NUM_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_addr  = '0;
        gnt_write = 1'b0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (!gnt_found && req_valid_i[i] &&
                    ((int'(rr_q) + k) % int'(NUM_REQ)) == i) begin
                    gnt_found = 1'b1;
                    gnt_idx   = RR_W'(i);
                    gnt_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
                    gnt_write = req_write_i[i];
                end
            end
        end
    end

    assign gnt_addr_al = gnt_addr & BLK_MASK;
    // Full is judged on the registered count: a same-cycle dequeue does not free a slot.
    assign full        = (count_q == CNT_W'(DEPTH));
    assign empty       = (count_q == '0);
    assign grant       = gnt_found && !full && !flush_i;
    assign req_ready_o = grant ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign enq         = grant && !hit;

    assign pf_valid_o = !empty && mshr_avail_i;
    assign fire       = pf_valid_o && pf_ready_i;
    assign pf_addr_o  = empty ? '0 : fifo_addr_q[rd_ptr_q];
    assign pf_cmd_o   = empty ? 5'b00000 : (fifo_wr_q[rd_ptr_q] ? M_PFW : M_PFR);

    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(fire);
        wr_ptr_d = wr_ptr_q + PTR_W'(enq);
        count_d  = count_q + CNT_W'(enq) - CNT_W'(fire);
        rr_d     = rr_q;
        if (grant) begin
            rr_d = (gnt_idx == RR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + RR_W'(1);
        end
        // A fire in the flush cycle is dropped along with everything else.
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            rr_d     = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            rr_q     <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            rr_q     <= rr_d;
            if (enq) begin
                fifo_addr_q[wr_ptr_q] <= gnt_addr_al;
                fifo_wr_q[wr_ptr_q]   <= gnt_write;
            end
        end
    end

`ifdef PF_FILTER_EN
    localparam int unsigned FW_W = (FILT_N > 1) ? $clog2(FILT_N) : 1;

    logic [ADDR_W-1:0] filt_addr_q [FILT_N];
    logic [FILT_N-1:0] filt_vld_q;
    logic [FW_W-1:0]   filt_ptr_q, filt_ptr_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic [PTR_W-1:0]  fifo_off;

    // Duplicate if the aligned address is in a live FIFO slot or a valid filter slot.
    always_comb begin
        hit      = 1'b0;
        fifo_off = '0;
        for (int j = 0; j < int'(DEPTH); j++) begin
            fifo_off = PTR_W'(j) - rd_ptr_q;
            if (({1'b0, fifo_off} < count_q) && (fifo_addr_q[j] == gnt_addr_al)) begin
                hit = 1'b1;
            end
        end
        for (int j = 0; j < int'(FILT_N); j++) begin
            if (filt_vld_q[j] && (filt_addr_q[j] == gnt_addr_al)) begin
                hit = 1'b1;
            end
        end
    end

    always_comb begin
        filt_ptr_d = filt_ptr_q;
        if (fire) begin
            filt_ptr_d = (filt_ptr_q == FW_W'(FILT_N - 1)) ? '0 : filt_ptr_q + FW_W'(1);
        end
        drop_cnt_d = drop_cnt_q;
        if (grant && hit && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            filt_vld_q <= '0;
            filt_ptr_q <= '0;
            drop_cnt_q <= '0;
        end else if (flush_i) begin
            filt_vld_q <= '0;
            filt_ptr_q <= '0;
        end else begin
            filt_ptr_q <= filt_ptr_d;
            drop_cnt_q <= drop_cnt_d;
            if (fire) begin
                filt_addr_q[filt_ptr_q] <= pf_addr_o;
                filt_vld_q[filt_ptr_q]  <= 1'b1;
            end
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`else
    assign hit        = 1'b0;
    assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_prefetch_issue_sched.sv
// Self-checking bench for prefetch_issue_sched: queue-based reference model
// compared every cycle, directed scenarios with literal expectations, then
// randomized traffic.
module tb_prefetch_issue_sched;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 40;
    localparam int DEPTH   = 4;
    localparam int FILT_N  = 4;
    localparam int LG_BLK  = 6;
`ifdef PF_FILTER_EN
    localparam bit FEN = 1'b1;
`else
    localparam bit FEN = 1'b0;
`endif

    logic                      clock;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      mshr_avail;
    logic                      flush;
    logic                      pf_valid;
    logic                      pf_ready;
    logic [ADDR_W-1:0]         pf_addr;
    logic [4:0]                pf_cmd;
    logic [15:0]               drop_cnt;

    prefetch_issue_sched #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .FILT_N(FILT_N), .LG_BLK(LG_BLK)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid_i  (req_valid),
        .req_addr_i   (req_addr),
        .req_write_i  (req_write),
        .req_ready_o  (req_ready),
        .mshr_avail_i (mshr_avail),
        .flush_i      (flush),
        .pf_valid_o   (pf_valid),
        .pf_ready_i   (pf_ready),
        .pf_addr_o    (pf_addr),
        .pf_cmd_o     (pf_cmd),
        .drop_cnt_o   (drop_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pending prefetches as a queue, recently issued addresses as a list.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wr;
    } ent_t;

    ent_t              mq[$];
    logic [ADDR_W-1:0] mfilt[$];
    int                mrr   = 0;
    int                mdrop = 0;

    logic [1:0]        obs_ready;
    logic              obs_pfv;
    logic [ADDR_W-1:0] obs_addr;
    logic [4:0]        obs_cmd;
    logic [15:0]       obs_drop;

    // Drive one cycle of inputs, compare DUT against the model at the falling edge,
    // then advance the model across the rising edge.
    task automatic cycle(input logic [1:0] v, input logic [ADDR_W-1:0] a0,
                         input logic [ADDR_W-1:0] a1, input logic [1:0] w,
                         input logic m, input logic f, input logic p, input logic r);
        int                g;
        logic              hit;
        logic [ADDR_W-1:0] ga;
        logic [1:0]        er;
        logic              epv;
        ent_t              e;
        reset      = r;
        req_valid  = v;
        req_addr   = {a1, a0};
        req_write  = w;
        mshr_avail = m;
        flush      = f;
        pf_ready   = p;
        @(negedge clock);
        obs_ready = req_ready;
        obs_pfv   = pf_valid;
        obs_addr  = pf_addr;
        obs_cmd   = pf_cmd;
        obs_drop  = drop_cnt;

        g = -1;
        if (mq.size() < DEPTH && !f) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (g < 0 && v[(mrr + k) % NUM_REQ]) g = (mrr + k) % NUM_REQ;
            end
        end
        ga  = ((g == 1) ? a1 : a0) & ~((40'd1 << LG_BLK) - 40'd1);
        hit = 1'b0;
        if (FEN && g >= 0) begin
            foreach (mq[i]) if (mq[i].addr == ga) hit = 1'b1;
            foreach (mfilt[i]) if (mfilt[i] == ga) hit = 1'b1;
        end
        er  = (g >= 0) ? (2'b01 << g) : 2'b00;
        epv = (mq.size() > 0) && m;

        if (!r) begin
            chk("req_ready", 64'(obs_ready), 64'(er));
            chk("pf_valid", 64'(obs_pfv), 64'(epv));
            if (epv) begin
                chk("pf_addr", 64'(obs_addr), 64'(mq[0].addr));
                chk("pf_cmd", 64'(obs_cmd), mq[0].wr ? 64'h3 : 64'h2);
            end
            chk("drop_cnt", 64'(obs_drop), 64'(mdrop));
        end

        if (r) begin
            mq.delete();
            mfilt.delete();
            mrr   = 0;
            mdrop = 0;
        end else if (f) begin
            mq.delete();
            mfilt.delete();
            mrr = 0;
        end else begin
            if (mq.size() > 0 && m && p) begin
                e = mq.pop_front();
                if (FEN) begin
                    mfilt.push_back(e.addr);
                    if (mfilt.size() > FILT_N) mfilt.delete(0);
                end
            end
            if (g >= 0) begin
                mrr = (g + 1) % NUM_REQ;
                if (hit) begin
                    if (mdrop < 65535) mdrop++;
                end else begin
                    e.addr = ga;
                    e.wr   = w[g];
                    mq.push_back(e);
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input logic m, input logic p);
        cycle(2'b00, '0, '0, 2'b00, m, 1'b0, p, 1'b0);
    endtask

    task automatic req0(input logic [ADDR_W-1:0] a, input logic m, input logic p);
        cycle(2'b01, a, '0, 2'b00, m, 1'b0, p, 1'b0);
    endtask

    task automatic do_flush();
        cycle(2'b00, '0, '0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [ADDR_W-1:0] ra0, ra1;

        // Reset state
        cycle(2'b00, '0, '0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
        cycle(2'b00, '0, '0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(1'b1, 1'b1);
        chk("rst_req_ready", 64'(obs_ready), 64'h0);
        chk("rst_pf_valid", 64'(obs_pfv), 64'h0);
        chk("rst_pf_addr", 64'(obs_addr), 64'h0);
        chk("rst_pf_cmd", 64'(obs_cmd), 64'h0);
        chk("rst_drop_cnt", 64'(obs_drop), 64'h0);

        // Single read request, issued one cycle later block-aligned
        req0(40'h1234, 1'b1, 1'b1);
        chk("tp1_ready", 64'(obs_ready), 64'h1);
        idle(1'b1, 1'b1);
        chk("tp1_pf_valid", 64'(obs_pfv), 64'h1);
        chk("tp1_pf_addr", 64'(obs_addr), 64'h1200);
        chk("tp1_pf_cmd", 64'(obs_cmd), 64'h2);
        idle(1'b1, 1'b1);

        // Round-robin alternation from rr = 0; requester 1 asks for write
        do_flush();
        for (int c = 0; c < 4; c++) begin
            cycle(2'b11, 40'h10000 + 40'(c) * 40'h100, 40'h20000 + 40'(c) * 40'h100,
                  2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
            chk("rr_grant", 64'(obs_ready), (c % 2 == 0) ? 64'h1 : 64'h2);
            if (c == 1) chk("rr_cmd_read", 64'(obs_cmd), 64'h2);
            if (c == 2) chk("rr_cmd_write", 64'(obs_cmd), 64'h3);
        end
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);

        // Fill to DEPTH with pf_ready low, then drain in order
        for (int c = 0; c < 5; c++) begin
            req0(40'h2000 + 40'(c) * 40'h40, 1'b1, 1'b0);
            chk("full_ready", 64'(obs_ready), (c < 4) ? 64'h1 : 64'h0);
        end
        for (int c = 0; c < 4; c++) begin
            idle(1'b1, 1'b1);
            chk("drain_valid", 64'(obs_pfv), 64'h1);
            chk("drain_addr", 64'(obs_addr), 64'h2000 + 64'(c) * 64'h40);
        end
        idle(1'b1, 1'b1);
        chk("drain_empty", 64'(obs_pfv), 64'h0);

        // MSHR back-pressure holds issue without loss or reordering
        req0(40'h3000, 1'b0, 1'b1);
        req0(40'h3040, 1'b0, 1'b1);
        chk("mshr_hold1", 64'(obs_pfv), 64'h0);
        idle(1'b0, 1'b1);
        chk("mshr_hold2", 64'(obs_pfv), 64'h0);
        idle(1'b1, 1'b1);
        chk("mshr_resume1", 64'(obs_addr), 64'h3000);
        idle(1'b1, 1'b1);
        chk("mshr_resume2", 64'(obs_addr), 64'h3040);
        idle(1'b1, 1'b1);

`ifdef PF_FILTER_EN
        // Same-block duplicate dropped from FIFO, then from the filter after issue
        do_flush();
        req0(40'h4000, 1'b1, 1'b0);
        req0(40'h4010, 1'b1, 1'b0);
        chk("filt_dup_ready", 64'(obs_ready), 64'h1);
        idle(1'b1, 1'b1);
        chk("filt_drop1", 64'(obs_drop), 64'h1);
        chk("filt_issue_addr", 64'(obs_addr), 64'h4000);
        idle(1'b1, 1'b1);
        chk("filt_one_issue", 64'(obs_pfv), 64'h0);
        req0(40'h4000, 1'b1, 1'b1);
        idle(1'b1, 1'b1);
        chk("filt_drop2", 64'(obs_drop), 64'h2);
        chk("filt_no_issue", 64'(obs_pfv), 64'h0);
`endif

        // Flush with three queued entries
        req0(40'h5000, 1'b1, 1'b0);
        req0(40'h5040, 1'b1, 1'b0);
        req0(40'h5080, 1'b1, 1'b0);
        cycle(2'b01, 40'h6000, '0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("flush_no_grant", 64'(obs_ready), 64'h0);
        req0(40'h6000, 1'b1, 1'b1);
        chk("flush_emptied", 64'(obs_pfv), 64'h0);
        chk("flush_new_ready", 64'(obs_ready), 64'h1);
        idle(1'b1, 1'b1);
        chk("flush_new_issue", 64'(obs_addr), 64'h6000);

        // Randomized traffic from a small address pool so duplicates occur
        for (int n = 0; n < 3000; n++) begin
            ra0 = 40'h7000 + 40'($urandom_range(0, 15)) * 40'h40 + 40'($urandom_range(0, 63));
            ra1 = 40'h7000 + 40'($urandom_range(0, 15)) * 40'h40 + 40'($urandom_range(0, 63));
            cycle(2'($urandom_range(0, 3)), ra0, ra1, 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) < 8), ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 299) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
